// File: rtl/rom_port_arbiter.sv
// Arbitrates one byte-wide ROM/RAM port between the download write stream
// (through a small FIFO), the video fetch path and the CPU.
module rom_port_arbiter #(
   parameter int AW         = 16,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic          MCLK,
   input  logic          RESET,
   input  logic          DLACT,
   input  logic [24:0]   ROMAD,
   input  logic [7:0]    ROMDT,
   input  logic          ROMEN,
   input  logic          VID_REQ,
   input  logic [AW-1:0] VID_AD,
   output logic [7:0]    VID_DT,
   output logic          VID_ACK,
   input  logic          CPU_REQ,
   input  logic [AW-1:0] CPU_AD,
   output logic [7:0]    CPU_DT,
   output logic          CPU_ACK,
   output logic [AW-1:0] MEM_AD,
   output logic [7:0]    MEM_WD,
   output logic          MEM_WE,
   output logic          MEM_RE,
   input  logic [7:0]    MEM_RD,
   output logic          DL_DONE,
   output logic          DL_OVF
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {IDLE, WRITE, ISSUE, WAIT, ACK} state_t;

   state_t          state, state_nx;
   logic [AW+7:0]   fifo_mem [FIFO_DEPTH];
   logic [PW:0]     wr_ptr, rd_ptr;
   logic [AW-1:0]   wr_addr, rd_addr;
   logic [7:0]      wr_data, vid_dt, cpu_dt;
   logic [SW-1:0]   starve;
   logic [WW-1:0]   wait_cnt;
   logic            sel_cpu, dlact_q, dl_pend, dl_ovf;
   logic            fifo_empty, fifo_full, in_range, pop, push, overflow;
   logic            gnt_vid, gnt_cpu, dl_done;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   // Out-of-range download addresses are dropped, never aliased.
   assign in_range   = ((ROMAD >> AW) == '0);
   assign pop        = (state == IDLE) && !fifo_empty;
   assign push       = ROMEN && in_range && (!fifo_full || pop);
   assign overflow   = ROMEN && in_range && fifo_full && !pop;
   assign dl_done    = !DLACT && (dl_pend || dlact_q) && fifo_empty && (state == IDLE);

   always_comb begin
      state_nx = state;
      gnt_vid  = 1'b0;
      gnt_cpu  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nx = WRITE;
            end else if (!DLACT) begin
               if (CPU_REQ && (starve == SW'(STARVE_MAX))) gnt_cpu = 1'b1;
               else if (VID_REQ)                          gnt_vid = 1'b1;
               else if (CPU_REQ)                          gnt_cpu = 1'b1;
               if (gnt_vid || gnt_cpu) state_nx = ISSUE;
            end
         end
         WRITE:   state_nx = IDLE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (wait_cnt == WW'(RD_LAT - 1)) state_nx = ACK;
         ACK:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge MCLK) begin
      if (push) fifo_mem[wr_ptr[PW-1:0]] <= {ROMAD[AW-1:0], ROMDT};
   end

   always_ff @(posedge MCLK) begin
      if (RESET) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         rd_addr  <= '0;
         vid_dt   <= '0;
         cpu_dt   <= '0;
         starve   <= '0;
         wait_cnt <= '0;
         sel_cpu  <= 1'b0;
         dlact_q  <= 1'b0;
         dl_pend  <= 1'b0;
         dl_ovf   <= 1'b0;
      end else begin
         state   <= state_nx;
         dlact_q <= DLACT;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            {wr_addr, wr_data} <= fifo_mem[rd_ptr[PW-1:0]];
            rd_ptr             <= rd_ptr + 1'b1;
         end
         if (gnt_vid || gnt_cpu) begin
            sel_cpu <= gnt_cpu;
            rd_addr <= gnt_cpu ? CPU_AD : VID_AD;
            starve  <= (gnt_vid && CPU_REQ) ? starve + 1'b1 : '0;
         end
         if (state == ISSUE)     wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
         if ((state == WAIT) && (state_nx == ACK)) begin
            if (sel_cpu) cpu_dt <= MEM_RD;
            else         vid_dt <= MEM_RD;
         end
         if (overflow)               dl_ovf <= 1'b1;
         else if (DLACT && !dlact_q) dl_ovf <= 1'b0;
         // Remember a falling edge until the FIFO has drained and the port is idle.
         if (DLACT || dl_done) dl_pend <= 1'b0;
         else if (dlact_q)     dl_pend <= 1'b1;
      end
   end

   assign MEM_WE  = (state == WRITE);
   assign MEM_RE  = (state == ISSUE);
   assign MEM_AD  = (state == WRITE) ? wr_addr : (state == ISSUE) ? rd_addr : '0;
   assign MEM_WD  = (state == WRITE) ? wr_data : '0;
   assign VID_ACK = (state == ACK) && !sel_cpu;
   assign CPU_ACK = (state == ACK) && sel_cpu;
   assign VID_DT  = vid_dt;
   assign CPU_DT  = cpu_dt;
   assign DL_DONE = dl_done;
   assign DL_OVF  = dl_ovf;

endmodule
